sata_rx_prim_decode: RTL and testbench

Receive-side primitive decoder that consumes the per-lane dword stream leaving the GTX wrapper (`rxdata_fis`/`rxcharisk`, one dword per `txusrclk20` cycle) and feeds the SATA link-layer state machine. It classifies each dword as a primitive, FIS data, or an error, and strips ALIGN. It expands CONT-suppressed streams so the link layer sees the repeated primitive every cycle. It also keeps saturating ALIGN and error counters for debug.

---
 rtl/sata_rx_prim_decode.sv | 175 +++++++++++++++++
 tb/tb_sata_rx_prim_decode.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_rx_prim_decode.sv
// SATA receive primitive decoder: classifies GTX dwords, strips ALIGN, expands CONT
// streams for the link layer and keeps saturating ALIGN / error statistics.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | no primitive held
// HOLD  | last emitted primitive stored in held
// CONT  | CONT seen after held; junk data stands for held
module sata_rx_prim_decode #(
    parameter int C_CNT_W       = 16,
    parameter bit C_CONT_EXPAND = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [31:0]        rx_data,
    input  logic [3:0]         rx_k,
    input  logic [3:0]         rx_err,
    input  logic               link_up,
    input  logic               clr_cnt,
    output logic               prim_valid,
    output logic [4:0]         prim_code,
    output logic               data_valid,
    output logic [31:0]        data,
    output logic               dec_err,
    output logic [C_CNT_W-1:0] align_cnt,
    output logic [C_CNT_W-1:0] err_cnt
);
    localparam logic [31:0] ALIGN_DW     = 32'h7B4A4ABC;
    localparam logic [31:0] CONT_DW      = 32'h9999AA7C;
    localparam logic [7:0]  K28_3        = 8'h7C;
    localparam logic [4:0]  CODE_UNKNOWN = 5'd31;

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_CONT} state_t;

    state_t      state, state_nxt;
    logic [4:0]  held, held_nxt;

    logic [31:0] s1_data;
    logic [3:0]  s1_k;
    logic [3:0]  s1_err;
    logic        s1_link;

    logic [4:0]  lookup_code;
    logic        k_prim, is_align, is_cont, is_prim, is_data;

    logic        pv_nxt, dv_nxt, err_nxt, align_ev;
    logic [4:0]  code_nxt;
    logic [31:0] data_nxt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_data <= '0;
            s1_k    <= '0;
            s1_err  <= '0;
            s1_link <= 1'b0;
        end else begin
            s1_data <= rx_data;
            s1_k    <= rx_k;
            s1_err  <= rx_err;
            s1_link <= link_up;
        end
    end

    always_comb begin : prim_lookup
        case (s1_data)
            32'hB5B5957C: lookup_code = 5'd1;
            32'h4A4A957C: lookup_code = 5'd2;
            32'h5757B57C: lookup_code = 5'd3;
            32'h3737B57C: lookup_code = 5'd4;
            32'hD5D5B57C: lookup_code = 5'd5;
            32'hD5D5AA7C: lookup_code = 5'd6;
            32'h9595AA7C: lookup_code = 5'd7;
            32'h5858B57C: lookup_code = 5'd8;
            32'h5555B57C: lookup_code = 5'd9;
            32'h3535B57C: lookup_code = 5'd10;
            32'h5656B57C: lookup_code = 5'd11;
            32'h3636B57C: lookup_code = 5'd12;
            32'h1717B57C: lookup_code = 5'd13;
            32'h7575957C: lookup_code = 5'd14;
            32'h9595957C: lookup_code = 5'd15;
            32'hF5F5957C: lookup_code = 5'd16;
            default:      lookup_code = CODE_UNKNOWN;
        endcase
    end

    // Anything that is not a clean data dword or a recognised K pattern is an error.
    always_comb begin : classify
        k_prim   = (s1_k == 4'b0001) && (s1_err == 4'b0000);
        is_align = k_prim && (s1_data == ALIGN_DW);
        is_cont  = k_prim && (s1_data == CONT_DW);
        is_prim  = k_prim && (s1_data[7:0] == K28_3) && !is_cont;
        is_data  = (s1_k == 4'b0000) && (s1_err == 4'b0000);
    end

    always_comb begin : fsm_comb
        state_nxt = state;
        held_nxt  = held;
        pv_nxt    = 1'b0;
        code_nxt  = '0;
        dv_nxt    = 1'b0;
        data_nxt  = '0;
        err_nxt   = 1'b0;
        align_ev  = 1'b0;
        if (!s1_link) begin
            state_nxt = ST_IDLE;
        end else if (is_align) begin
            align_ev = 1'b1;
        end else if (is_prim) begin
            pv_nxt    = 1'b1;
            code_nxt  = lookup_code;
            held_nxt  = lookup_code;
            state_nxt = ST_HOLD;
        end else if (is_cont) begin
            if (state == ST_HOLD) begin
                state_nxt = ST_CONT;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (is_data) begin
            if (state == ST_CONT) begin
                if (C_CONT_EXPAND) begin
                    pv_nxt   = 1'b1;
                    code_nxt = held;
                end
            end else begin
                dv_nxt   = 1'b1;
                data_nxt = s1_data;
            end
        end else begin
            err_nxt = 1'b1;
            if (state == ST_HOLD) begin
                state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            held       <= '0;
            prim_valid <= 1'b0;
            prim_code  <= '0;
            data_valid <= 1'b0;
            data       <= '0;
            dec_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            held       <= held_nxt;
            prim_valid <= pv_nxt;
            prim_code  <= code_nxt;
            data_valid <= dv_nxt;
            data       <= data_nxt;
            dec_err    <= err_nxt;
        end
    end

    // clr_cnt is not pipelined: it acts on whichever event is in stage 2 that cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            align_cnt <= '0;
            err_cnt   <= '0;
        end else if (clr_cnt) begin
            align_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (align_ev && (align_cnt != '1)) begin
                align_cnt <= align_cnt + 1'b1;
            end
            if (err_nxt && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sata_rx_prim_decode.sv
// Bench for sata_rx_prim_decode: two DUTs (CONT expand on/off) driven in lockstep and
// checked every cycle against a dword-level reference model plus literal expectations.
module tb_sata_rx_prim_decode;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int NX   = 1024;

    localparam logic [31:0] W_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] W_CONT  = 32'h9999AA7C;
    localparam logic [31:0] SYNC    = 32'hB5B5957C;
    localparam logic [31:0] X_RDY   = 32'h5757B57C;
    localparam logic [31:0] SOF     = 32'h3737B57C;
    localparam logic [31:0] R_IP    = 32'h5555B57C;
    localparam logic [31:0] R_OK    = 32'h3535B57C;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [31:0]   rx_data   = '0;
    logic [3:0]    rx_k      = '0;
    logic [3:0]    rx_err    = '0;
    logic          link_up   = 1'b0;
    logic          clr_cnt   = 1'b0;

    logic          a_pv, a_dv, a_derr, b_pv, b_dv, b_derr;
    logic [4:0]    a_code, b_code;
    logic [31:0]   a_data, b_data;
    logic [CW-1:0] a_acnt, a_ecnt, b_acnt, b_ecnt;

    always #5 sys_clk = ~sys_clk;

    sata_rx_prim_decode #(.C_CNT_W(CW), .C_CONT_EXPAND(1'b1)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_k(rx_k),
        .rx_err(rx_err), .link_up(link_up), .clr_cnt(clr_cnt),
        .prim_valid(a_pv), .prim_code(a_code), .data_valid(a_dv), .data(a_data),
        .dec_err(a_derr), .align_cnt(a_acnt), .err_cnt(a_ecnt)
    );

    sata_rx_prim_decode #(.C_CNT_W(CW), .C_CONT_EXPAND(1'b0)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_k(rx_k),
        .rx_err(rx_err), .link_up(link_up), .clr_cnt(clr_cnt),
        .prim_valid(b_pv), .prim_code(b_code), .data_valid(b_dv), .data(b_data),
        .dec_err(b_derr), .align_cnt(b_acnt), .err_cnt(b_ecnt)
    );

    // Primitive dword for code i (index = code).
    logic [31:0] prim_tab [1:16] = '{
        32'hB5B5957C, 32'h4A4A957C, 32'h5757B57C, 32'h3737B57C,
        32'hD5D5B57C, 32'hD5D5AA7C, 32'h9595AA7C, 32'h5858B57C,
        32'h5555B57C, 32'h3535B57C, 32'h5656B57C, 32'h3636B57C,
        32'h1717B57C, 32'h7575957C, 32'h9595957C, 32'hF5F5957C
    };

    bit          e_set     [NX];
    bit          e_cnt_set [NX];
    bit          l_set     [NX];
    bit          l_is_data [NX];
    logic        e_pv      [NX];
    logic        e_pvb     [NX];
    logic        e_dv      [NX];
    logic        e_derr    [NX];
    int          e_code    [NX];
    logic [31:0] e_data    [NX];
    int          e_acnt    [NX];
    int          e_ecnt    [NX];
    int          l_code    [NX];
    logic [31:0] l_data    [NX];

    int cyc      = 0;
    int n_cmp    = 0;
    int n_bad    = 0;
    int last_idx = 0;

    // Model state: 0 = nothing held, 1 = primitive held, 2 = repeating held.
    int m_st, m_held, m_acnt, m_ecnt;
    bit pend_align, pend_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e,
                         input logic lk, input int idx);
        bit pv, pvb, dv, derr, pa, is_dat, is_k1;
        int code, hit;
        pv = 0; pvb = 0; dv = 0; derr = 0; pa = 0; code = 0; hit = 0;
        is_dat = (k == 4'b0000) && (e == 4'b0000);
        is_k1  = (k == 4'b0001) && (e == 4'b0000);
        for (int i = 1; i <= 16; i++) if (prim_tab[i] == d) hit = i;
        if (!lk) begin
            m_st = 0;
        end else if (is_k1 && d == W_ALIGN) begin
            pa = 1;
        end else if (is_k1 && d == W_CONT) begin
            if (m_st == 1) m_st = 2;
            else derr = 1;
        end else if (is_k1 && d[7:0] == 8'h7C) begin
            code = (hit == 0) ? 31 : hit;
            pv = 1; pvb = 1; m_held = code; m_st = 1;
        end else if (is_dat) begin
            if (m_st == 2) begin
                pv = 1; code = m_held;
            end else begin
                dv = 1;
            end
        end else begin
            derr = 1;
            if (m_st == 1) m_st = 0;
        end
        if (idx < NX) begin
            e_set[idx] = 1; e_pv[idx] = pv; e_pvb[idx] = pvb; e_code[idx] = code;
            e_dv[idx] = dv; e_data[idx] = d; e_derr[idx] = derr;
        end
        pend_align = pa;
        pend_err   = derr;
    endtask

    // Must be called every cycle between resets: counter expectations rely on it.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e,
                        input logic lk, input logic clr);
        @(negedge sys_clk);
        rx_data = d; rx_k = k; rx_err = e; link_up = lk; clr_cnt = clr;
        if (clr) begin
            m_acnt = 0; m_ecnt = 0;
        end else begin
            if (pend_align && m_acnt < CMAX) m_acnt++;
            if (pend_err && m_ecnt < CMAX) m_ecnt++;
        end
        if (cyc + 1 < NX) begin
            e_cnt_set[cyc+1] = 1; e_acnt[cyc+1] = m_acnt; e_ecnt[cyc+1] = m_ecnt;
        end
        model(d, k, e, lk, cyc + 2);
        last_idx = cyc + 2;
    endtask

    task automatic prim(input logic [31:0] d);
        send(d, 4'b0001, 4'b0000, 1'b1, 1'b0);
    endtask

    task automatic dat(input logic [31:0] d);
        send(d, 4'b0000, 4'b0000, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) send(32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic lit_code(input int c);
        if (last_idx < NX) begin
            l_set[last_idx] = 1; l_is_data[last_idx] = 0; l_code[last_idx] = c;
        end
    endtask

    task automatic lit_data(input logic [31:0] d);
        if (last_idx < NX) begin
            l_set[last_idx] = 1; l_is_data[last_idx] = 1; l_data[last_idx] = d;
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        rx_data = '0; rx_k = '0; rx_err = '0; link_up = 1'b0; clr_cnt = 1'b0;
        for (int i = cyc; i < cyc + 4 && i < NX; i++) begin
            e_set[i] = 0; e_cnt_set[i] = 0; l_set[i] = 0;
        end
        m_st = 0; m_held = 0; m_acnt = 0; m_ecnt = 0; pend_align = 0; pend_err = 0;
        #1;
        chk("rst_a_pv",   32'(a_pv),   0);
        chk("rst_a_code", 32'(a_code), 0);
        chk("rst_a_dv",   32'(a_dv),   0);
        chk("rst_a_data", a_data,      0);
        chk("rst_a_derr", 32'(a_derr), 0);
        chk("rst_a_acnt", 32'(a_acnt), 0);
        chk("rst_a_ecnt", 32'(a_ecnt), 0);
        chk("rst_b_pv",   32'(b_pv),   0);
        chk("rst_b_code", 32'(b_code), 0);
        chk("rst_b_acnt", 32'(b_acnt), 0);
        chk("rst_b_ecnt", 32'(b_ecnt), 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin : compare
        forever begin
            @(posedge sys_clk);
            cyc = cyc + 1;
            #1;
            if (cyc < NX) begin
                if (e_set[cyc]) begin
                    chk("a_prim_valid", 32'(a_pv), 32'(e_pv[cyc]));
                    if (e_pv[cyc]) chk("a_prim_code", 32'(a_code), e_code[cyc]);
                    chk("a_data_valid", 32'(a_dv), 32'(e_dv[cyc]));
                    if (e_dv[cyc]) chk("a_data", a_data, e_data[cyc]);
                    chk("a_dec_err", 32'(a_derr), 32'(e_derr[cyc]));
                    chk("b_prim_valid", 32'(b_pv), 32'(e_pvb[cyc]));
                    if (e_pvb[cyc]) chk("b_prim_code", 32'(b_code), e_code[cyc]);
                    chk("b_data_valid", 32'(b_dv), 32'(e_dv[cyc]));
                    if (e_dv[cyc]) chk("b_data", b_data, e_data[cyc]);
                    chk("b_dec_err", 32'(b_derr), 32'(e_derr[cyc]));
                end
                if (e_cnt_set[cyc]) begin
                    chk("a_align_cnt", 32'(a_acnt), e_acnt[cyc]);
                    chk("a_err_cnt",   32'(a_ecnt), e_ecnt[cyc]);
                    chk("b_align_cnt", 32'(b_acnt), e_acnt[cyc]);
                    chk("b_err_cnt",   32'(b_ecnt), e_ecnt[cyc]);
                end
                if (l_set[cyc]) begin
                    if (l_is_data[cyc]) begin
                        chk("lit_data_valid", 32'(a_dv), 1);
                        chk("lit_data", a_data, l_data[cyc]);
                    end else begin
                        chk("lit_prim_valid", 32'(a_pv), 1);
                        chk("lit_prim_code", 32'(a_code), l_code[cyc]);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        repeat (2) @(posedge sys_clk);
        do_reset();
        idle(2);

        for (int i = 0; i < 3; i++) begin
            prim(SYNC); lit_code(1);
        end
        idle(3);
        chk("sync_align_cnt", 32'(a_acnt), 0);
        chk("sync_err_cnt", 32'(a_ecnt), 0);

        prim(X_RDY); lit_code(3);
        prim(W_CONT);
        for (int i = 0; i < 5; i++) begin
            dat($urandom()); lit_code(3);
        end
        prim(R_OK); lit_code(10);
        idle(2);

        send(32'h0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        prim(SOF); lit_code(4);
        prim(W_ALIGN);
        prim(W_ALIGN);
        dat(32'h12345678); lit_data(32'h12345678);
        idle(3);
        chk("align_cnt_two", 32'(a_acnt), 2);

        prim(SYNC); lit_code(1);
        send(32'h11223344, 4'b0010, 4'b0000, 1'b1, 1'b0);
        dat(32'hCAFEF00D); lit_data(32'hCAFEF00D);
        idle(3);
        chk("err_cnt_one", 32'(a_ecnt), 1);

        prim(W_CONT);
        prim(32'h0000007C); lit_code(31);
        send(SYNC, 4'b0001, 4'b0000, 1'b0, 1'b0);
        idle(3);
        chk("err_cnt_two", 32'(a_ecnt), 2);

        // ALIGN, a second CONT and an error inside a CONT run all keep it running
        prim(X_RDY); lit_code(3);
        prim(W_CONT);
        dat(32'hA5A5A5A5); lit_code(3);
        prim(W_ALIGN);
        dat(32'h5A5A5A5A); lit_code(3);
        prim(W_CONT);
        dat(32'h01020304); lit_code(3);
        send(32'h77777777, 4'b0000, 4'b0001, 1'b1, 1'b0);
        dat(32'h0F0F0F0F); lit_code(3);
        prim(SYNC); lit_code(1);
        idle(3);
        chk("err_cnt_four", 32'(a_ecnt), 4);

        for (int i = 0; i < 10; i++) send(32'hDEAD0000 + i, 4'b0000, 4'b0100, 1'b1, 1'b0);
        idle(3);
        chk("err_cnt_max_m1", 32'(a_ecnt), CMAX - 1);
        for (int i = 0; i < 3; i++) send(32'hBEEF0000, 4'b1000, 4'b0000, 1'b1, 1'b0);
        idle(3);
        chk("err_cnt_sat", 32'(a_ecnt), CMAX);
        chk("align_cnt_three", 32'(a_acnt), 3);

        prim(W_ALIGN);
        send(32'h0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        idle(3);
        chk("clr_align_cnt", 32'(a_acnt), 0);
        chk("clr_err_cnt", 32'(a_ecnt), 0);

        prim(W_ALIGN);
        prim(R_IP); lit_code(9);
        prim(W_CONT);
        dat(32'h13572468);
        dat(32'h24681357);
        do_reset();
        idle(1);
        dat(32'h0BADBEEF); lit_data(32'h0BADBEEF);
        prim(SYNC); lit_code(1);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
